// File: rtl/mux.sv
// mux: sequential 8x8 multiplier producing both the unsigned and the
// two's-complement signed product of one operand pair. A fixed 10-cycle
// frame (LOAD, eight CALC steps, DONE) repeats forever. Operands are
// captured when LOAD is left. Results are published together, with a
// one-cycle done pulse.
module mux (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:7]  A,
    input  logic [0:7]  B,
    output logic [0:15] Z,
    output logic [0:15] Y,
    output logic        done
);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    // Captured operands, held in conventional [7:0] order (bit 7 = MSB)
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [2:0]  count;

    // Unsigned accumulator: the upper half collects partial sums and the
    // lower half receives the bits shifted out
    logic [15:0] acc_u;
    // Signed Booth accumulator, handled with arithmetic shifts
    logic [15:0] acc_s;

    logic        bit_cur;
    logic        bit_prev;
    logic [8:0]  u_sum;
    logic [8:0]  s_upper;
    logic [8:0]  a_ext;
    logic [8:0]  s_sum;

    // State register; reset parks the frame in LOAD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: LOAD -> eight CALC steps -> DONE -> LOAD
    always_comb begin
        next_state = state;
        case (state)
            S_LOAD: next_state = S_CALC;
            S_CALC: if (count == 3'd7) next_state = S_DONE;
            S_DONE: next_state = S_LOAD;
            default: next_state = S_LOAD;
        endcase
    end

    // One step of each multiplier path, computed from the current multiplier bit.
    // The 9-bit signed adder keeps the result exact for A = -128.
    always_comb begin
        bit_cur  = b_reg[count];
        bit_prev = 1'b0;
        if (count != 3'd0) begin
            bit_prev = b_reg[count - 3'd1];
        end

        u_sum = {1'b0, acc_u[15:8]} + (bit_cur ? {1'b0, a_reg} : 9'd0);

        s_upper = {acc_s[15], acc_s[15:8]};
        a_ext   = {a_reg[7], a_reg};
        case ({bit_cur, bit_prev})
            2'b01:   s_sum = s_upper + a_ext;
            2'b10:   s_sum = s_upper - a_ext;
            default: s_sum = s_upper;
        endcase
    end

    // Datapath: capture in LOAD, shift-add and Booth steps in CALC,
    // publish on the last CALC edge, and drop done when DONE is left
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg <= 8'd0;
            b_reg <= 8'd0;
            count <= 3'd0;
            acc_u <= 16'd0;
            acc_s <= 16'd0;
            Z     <= 16'd0;
            Y     <= 16'd0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    a_reg <= A;
                    b_reg <= B;
                    count <= 3'd0;
                    acc_u <= 16'd0;
                    acc_s <= 16'd0;
                end
                S_CALC: begin
                    acc_u <= {u_sum, acc_u[7:1]};
                    acc_s <= {s_sum, acc_s[7:1]};
                    count <= count + 3'd1;
                    if (count == 3'd7) begin
                        Z    <= {u_sum, acc_u[7:1]};
                        Y    <= {s_sum, acc_s[7:1]};
                        done <= 1'b1;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux.sv
// tb_mux: directed bench for mux. A frame-timeline model predicts Z/Y/done
// from plain integer products, and the outputs are compared with it on every
// cycle. Hand-computed literals pin the published results.
module tb_mux;

    logic        clk;
    logic        rst;
    logic [0:7]  A;
    logic [0:7]  B;
    logic [0:15] Z;
    logic [0:15] Y;
    logic        done;

    int checks   = 0;
    int failures = 0;

    mux dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Z    (Z),
        .Y    (Y),
        .done (done)
    );

    // Free-running clock with a 10-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-timeline model: edge 0 of a frame samples the operands, and
    // edge 8 publishes exact products. Edge 9 ends the done pulse.
    int          phase = 0;
    logic [7:0]  ma = 8'd0;
    logic [7:0]  mb = 8'd0;
    logic [15:0] mz = 16'd0;
    logic [15:0] my = 16'd0;
    logic        mdone = 1'b0;

    function automatic logic [15:0] sprod(input logic [7:0] x, input logic [7:0] y);
        int sx;
        int sy;
        int p;
        sx = (x >= 8'd128) ? int'(x) - 256 : int'(x);
        sy = (y >= 8'd128) ? int'(y) - 256 : int'(y);
        p  = sx * sy;
        return p[15:0];
    endfunction

    // Model update on each clock edge, with immediate clearing when reset is asserted
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= 0;
            mz    <= 16'd0;
            my    <= 16'd0;
            mdone <= 1'b0;
        end else begin
            if (phase == 0) begin
                ma <= A;
                mb <= B;
            end
            if (phase == 8) begin
                mz    <= 16'(int'(ma) * int'(mb));
                my    <= sprod(ma, mb);
                mdone <= 1'b1;
            end
            if (phase == 9) begin
                mdone <= 1'b0;
            end
            phase <= (phase + 1) % 10;
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model, away from the active edge
    always @(negedge clk) begin
        checks++;
        if (Z !== mz || Y !== my || done !== mdone) begin
            failures++;
            $display("[TB] FAIL model t=%0t Z=%h Y=%h done=%b required Z=%h Y=%h done=%b",
                     $time, Z, Y, done, mz, my, mdone);
        end
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        #1;
        A = a;
        B = b;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] ez, input logic [15:0] ey);
        checks++;
        if (Z !== ez || Y !== ey || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s Z=%h Y=%h done=%b required Z=%h Y=%h done=1",
                     name, Z, Y, done, ez, ey);
        end
    endtask

    task automatic checkZero(input string name);
        checks++;
        if (Z !== 16'd0 || Y !== 16'd0 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s Z=%h Y=%h done=%b required all zero", name, Z, Y, done);
        end
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout done=%b required done=1 within 30 cycles", name, done);
        end
    endtask

    // Directed sequence
    initial begin
        A   = 8'h00;
        B   = 8'h00;
        rst = 1'b1;
        #1 rst = 1'b0;

        repeat (4) @(negedge clk);
        checkZero("reset_hold");

        applyStimulus(8'hCC, 8'hE2);
        rst = 1'b1;
        waitDone("mixed");
        checkOutput("mixed", 16'hB418, 16'h0618);

        applyStimulus(8'hF0, 8'h0F);
        @(negedge clk);
        waitDone("contrast");
        checkOutput("contrast", 16'h0E10, 16'hFF10);

        applyStimulus(8'hAA, 8'h55);
        @(negedge clk);
        waitDone("alternating");
        checkOutput("alternating", 16'h3872, 16'hE372);

        applyStimulus(8'h80, 8'h80);
        @(negedge clk);
        waitDone("min_min");
        checkOutput("min_min", 16'h4000, 16'h4000);

        applyStimulus(8'hFF, 8'hFF);
        @(negedge clk);
        waitDone("ones");
        checkOutput("ones", 16'hFE01, 16'h0001);

        applyStimulus(8'h00, 8'h5A);
        @(negedge clk);
        waitDone("zero_a");
        checkOutput("zero_a", 16'h0000, 16'h0000);

        // Operands changed mid-CALC must not affect the result
        applyStimulus(8'h37, 8'h91);
        repeat (5) @(negedge clk);
        applyStimulus(8'hFF, 8'hFF);
        waitDone("mid_change");
        checkOutput("mid_change", 16'h1F27, 16'hE827);

        // Reset asserted inside CALC clears the outputs immediately
        applyStimulus(8'h12, 8'h34);
        repeat (4) @(negedge clk);
        #1 rst = 1'b0;
        #1 checkZero("mid_reset");
        @(negedge clk);
        checkZero("mid_reset_hold");

        // Release reset; the product appears nine edges later
        applyStimulus(8'h9C, 8'h07);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        checkZero("post_reset_no_partial");
        @(negedge clk);
        checkOutput("post_reset", 16'h0444, 16'hFD44);

        repeat (12) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
